// File: rtl/scan_sequencer.sv
// scan_sequencer: round-robin 4-channel decoder scanner with per-slot blanking; SCAN_DIM_EN adds PWM dimming
module scan_sequencer #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int DW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [3:0]    mask,
  input  logic [4*DW-1:0] din,
`ifdef SCAN_DIM_EN
  input  logic [3:0]    duty,
`endif
  output logic [1:0]    w,
  output logic          E,
  output logic [DW-1:0] dout,
  output logic          slot_start
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    w_q, w_d, ch;
  logic          e_q, e_d, ss_q, ss_d, start;
  logic [DW-1:0] dout_q, dout_d;
`ifdef SCAN_DIM_EN
  logic [3:0]    pwm_q, pwm_d;
`endif
  function automatic logic [1:0] first_from(input logic [1:0] base, input logic [3:0] m);
    logic [1:0] idx;
    first_from = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (m[idx]) first_from = idx;
    end
  endfunction
  // next-state: stop beats slot change beats normal counting; any new slot reloads w/dout and pulses slot_start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    dout_d  = dout_q;
    e_d     = 1'b1;
    ss_d    = 1'b0;
    start   = 1'b0;
`ifdef SCAN_DIM_EN
    pwm_d   = pwm_q;
`endif
    ch = first_from((state_q == IDLE) ? 2'd0 : w_q + 2'd1, mask);
    if (state_q == IDLE) begin
      start = run && |mask;
    end else if (!run || mask == 4'd0) begin
      state_d = IDLE;
    end else if (!mask[w_q] || (state_q == ON && cnt_q == SLOT_LAST)) begin
      start = 1'b1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (state_q == ON || cnt_q == BLANK_LAST) ? ON : BLANK;
`ifdef SCAN_DIM_EN
      pwm_d   = (state_q == ON) ? pwm_q + 4'd1 : 4'd0;
      e_d     = (state_d == ON) ? (pwm_d > duty) : 1'b1;
`else
      e_d     = state_d != ON;
`endif
    end
    if (start) begin
      state_d = BLANK;
      cnt_d   = '0;
      w_d     = ch;
      dout_d  = din[int'(ch)*DW +: DW];
      ss_d    = 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      e_q     <= 1'b1;
      dout_q  <= '0;
      ss_q    <= 1'b0;
`ifdef SCAN_DIM_EN
      pwm_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      e_q     <= e_d;
      dout_q  <= dout_d;
      ss_q    <= ss_d;
`ifdef SCAN_DIM_EN
      pwm_q   <= pwm_d;
`endif
    end
  end
  assign w          = w_q;
  assign E          = e_q;
  assign dout       = dout_q;
  assign slot_start = ss_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed and randomized checks of scan_sequencer against a slot-position model
module tb_scan_sequencer;
`ifdef SCAN_DIM_EN
  localparam int TD = 34;
`else
  localparam int TD = 8;
`endif
  localparam int BC = 2;
  logic        clk = 1'b0;
  logic        rst_n, run;
  logic [3:0]  mask, duty;
  logic [15:0] din;
  logic [1:0]  w;
  logic        E, slot_start;
  logic [3:0]  dout;
  int          n_chk = 0, n_pass = 0;
  bit          m_act;
  int          m_pos;
  logic [1:0]  m_w;
  logic [3:0]  m_dout;
  logic        m_ss;

  scan_sequencer #(.TICK_DIV(TD), .BLANK_CYC(BC), .DW(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mask(mask), .din(din),
`ifdef SCAN_DIM_EN
    .duty(duty),
`endif
    .w(w), .E(E), .dout(dout), .slot_start(slot_start)
  );

  always #5 clk = ~clk;

  function automatic logic m_e();
    return !(m_act && m_pos >= BC && ((m_pos - BC) % 16) <= int'(duty));
  endfunction

  task automatic m_start(input logic [1:0] c);
    m_act  = 1'b1;
    m_pos  = 0;
    m_w    = c;
    m_dout = din[int'(c)*4 +: 4];
    m_ss   = 1'b1;
  endtask

  task automatic model_step();
    logic [1:0] c = 2'd0;
    m_ss = 1'b0;
    if (!rst_n) begin
      m_act = 1'b0; m_pos = 0; m_w = 2'd0; m_dout = 4'd0;
    end else if (!m_act) begin
      if (run && mask != 4'd0) begin
        for (int k = 3; k >= 0; k--) if (mask[k]) c = 2'(k);
        m_start(c);
      end
    end else if (!run || mask == 4'd0) begin
      m_act = 1'b0;
    end else if (!mask[m_w] || m_pos == TD - 1) begin
      for (int k = 4; k >= 1; k--) if (mask[(int'(m_w) + k) % 4]) c = 2'((int'(m_w) + k) % 4);
      m_start(c);
    end else begin
      m_pos++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; mask = 4'hF; din = 16'hDCBA; duty = 4'd15;
    repeat (3) begin
      tick();
      n_chk++;
      if ({w, E, dout, slot_start} !== 8'b00_1_0000_0)
        $display("FAIL reset got=%h exp=%h", {w, E, dout, slot_start}, 8'b00_1_0000_0);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] seen[$];
    logic [5:0] want[5] = '{6'h0A, 6'h1B, 6'h2C, 6'h3D, 6'h0A};
    rst_n = 1'b1;
    for (int i = 0; i < 5*TD; i++) begin
      tick();
      n_chk++;
      if ({w, E, dout, slot_start} !== {m_w, m_e(), m_dout, m_ss})
        $display("FAIL rr cyc=%0d got=%h exp=%h", i, {w, E, dout, slot_start}, {m_w, m_e(), m_dout, m_ss});
      else n_pass++;
      if (slot_start) seen.push_back({w, dout});
    end
    n_chk++;
    if (seen.size() != 5) $display("FAIL rr_slots got=%0d exp=5", seen.size());
    else n_pass++;
    for (int i = 0; i < seen.size() && i < 5; i++) begin
      n_chk++;
      if (seen[i] !== want[i]) $display("FAIL rr_seq idx=%0d got=%h exp=%h", i, seen[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mask_patterns();
    mask = 4'b1010;
    for (int i = 0; i < 4*TD; i++) begin
      tick();
      n_chk++;
      if ({w, E, dout, slot_start} !== {m_w, m_e(), m_dout, m_ss})
        $display("FAIL m1010 cyc=%0d got=%h exp=%h", i, {w, E, dout, slot_start}, {m_w, m_e(), m_dout, m_ss});
      else n_pass++;
      if (slot_start) begin
        n_chk++;
        if (w != 2'd1 && w != 2'd3) $display("FAIL m1010_w got=%0d exp=1or3", w);
        else n_pass++;
      end
    end
    mask = 4'b0100;
    for (int i = 0; i < 3*TD; i++) begin
      tick();
      n_chk++;
      if ({w, E, dout, slot_start} !== {m_w, m_e(), m_dout, m_ss})
        $display("FAIL m0100 cyc=%0d got=%h exp=%h", i, {w, E, dout, slot_start}, {m_w, m_e(), m_dout, m_ss});
      else n_pass++;
    end
  endtask

  task automatic test_mask_clear();
    bit found = 1'b0;
    rst_n = 1'b0; mask = 4'hF; tick(); rst_n = 1'b1;
    for (int i = 0; i < 4*TD && !found; i++) begin
      tick();
      if (w == 2'd1 && E == 1'b0) found = 1'b1;
    end
    n_chk++;
    if (!found) $display("FAIL clr_wait got=timeout exp=ON of ch1");
    else n_pass++;
    mask = 4'b1101;
    tick();
    n_chk++;
    if ({w, E, dout, slot_start} !== {2'd2, 1'b1, 4'hC, 1'b1})
      $display("FAIL clr_next got=%h exp=%h", {w, E, dout, slot_start}, {2'd2, 1'b1, 4'hC, 1'b1});
    else n_pass++;
  endtask

  task automatic test_run_stop();
    bit found = 1'b0;
    rst_n = 1'b0; mask = 4'hF; run = 1'b1; tick(); rst_n = 1'b1;
    for (int i = 0; i < 5*TD && !found; i++) begin
      tick();
      if (w == 2'd3 && E == 1'b0) found = 1'b1;
    end
    n_chk++;
    if (!found) $display("FAIL stop_wait got=timeout exp=ON of ch3");
    else n_pass++;
    run = 1'b0;
    repeat (4) begin
      tick();
      n_chk++;
      if ({w, E, dout, slot_start} !== {2'd3, 1'b1, 4'hD, 1'b0})
        $display("FAIL stop_idle got=%h exp=%h", {w, E, dout, slot_start}, {2'd3, 1'b1, 4'hD, 1'b0});
      else n_pass++;
    end
    mask = 4'b1000; run = 1'b1;
    tick();
    n_chk++;
    if ({w, E, dout, slot_start} !== {2'd3, 1'b1, 4'hD, 1'b1})
      $display("FAIL restart got=%h exp=%h", {w, E, dout, slot_start}, {2'd3, 1'b1, 4'hD, 1'b1});
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++;
    if ({w, E, dout, slot_start} !== 8'b00_1_0000_0)
      $display("FAIL blank_reset got=%h exp=%h", {w, E, dout, slot_start}, 8'b00_1_0000_0);
    else n_pass++;
    rst_n = 1'b1;
  endtask

`ifdef SCAN_DIM_EN
  task automatic test_dim();
    logic exp_e;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mask = 4'b0001; run = 1'b1; duty = 4'd3;
    tick();
    n_chk++;
    if (slot_start !== 1'b1) $display("FAIL dim_start got=%b exp=1", slot_start);
    else n_pass++;
    tick();
    for (int i = 0; i < TD - BC; i++) begin
      tick();
      exp_e = !(i < 4 || (i >= 16 && i < 20));
      n_chk++;
      if (E !== exp_e || E !== m_e()) $display("FAIL dim_on i=%0d got=%b exp=%b", i, E, exp_e);
      else n_pass++;
    end
    tick();
    n_chk++;
    if ({E, slot_start} !== 2'b11) $display("FAIL dim_next got=%b exp=11", {E, slot_start});
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 59) == 0) run = ~run;
      if ($urandom_range(0, 3*TD) == 0) mask = 4'($urandom);
      din = 16'($urandom);
`ifdef SCAN_DIM_EN
      if ($urandom_range(0, 99) == 0) duty = 4'($urandom);
`endif
      tick();
      n_chk++;
      if ({w, E, dout, slot_start} !== {m_w, m_e(), m_dout, m_ss})
        $display("FAIL rand cyc=%0d got=%h exp=%h", i, {w, E, dout, slot_start}, {m_w, m_e(), m_dout, m_ss});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mask_patterns();
    test_mask_clear();
    test_run_stop();
`ifdef SCAN_DIM_EN
    test_dim();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
